// File: rtl/dsp_mac_pkg.sv
// Shared constants for the DSP48A1 multiply-accumulate sequencer:
// slice field widths, opmode codes and the controller state encoding.
package dsp_mac_pkg;

  localparam int A_W = 18;
  localparam int M_W = 36;
  localparam int P_W = 48;

  // Z = C, X = M: load bias plus first product
  localparam logic [7:0] OPM_FIRST = 8'h0D;
  // Z = P, X = M: accumulate next product
  localparam logic [7:0] OPM_ACC   = 8'h09;
  // Z = P, X = 0: keep P unchanged
  localparam logic [7:0] OPM_HOLD  = 8'h08;
  // Slice idle
  localparam logic [7:0] OPM_ZERO  = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dsp_opm_skew.sv
// Fixed-depth opmode delay line; every stage resets to the idle opmode.
module dsp_opm_skew
  import dsp_mac_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] pipe [DEPTH];

  // Shift the opmode one stage per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= OPM_ZERO;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Dot-product sequencer for one DSP48A1 slice. Streams operand pairs onto
// A/B, skews the matching opmode behind them, waits for the slice pipeline
// to drain and hands out P as a single result.
// Optional: DSP_MAC_CARRY_FLAG_EN adds a sticky 48-bit wraparound flag.
//
//   state | meaning
//   IDLE  | waiting for start with a non-zero length
//   RUN   | accepting operand pairs, issuing FIRST/ACC/HOLD
//   DRAIN | slice pipeline flushing, counting down LAT_P
//   DONE  | result held until res_ready
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int LAT_P    = 3,
  parameter int OPM_SKEW = 1,
  parameter int LEN_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [P_W-1:0]   c_init,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [A_W-1:0]   s_a,
  input  logic [A_W-1:0]   s_b,
  output logic [A_W-1:0]   dsp_a,
  output logic [A_W-1:0]   dsp_b,
  output logic [P_W-1:0]   dsp_c,
  output logic [7:0]       dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [P_W-1:0]   res_data
`ifdef DSP_MAC_CARRY_FLAG_EN
  ,
  input  logic             dsp_carryout,
  output logic             res_carry
`endif
);

  localparam int DW = $clog2(LAT_P + 1);

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic [DW-1:0]    drain_cnt;
  logic             first;
  logic [7:0]       opm_in;

  // Opmode is registered here and delayed OPM_SKEW more cycles than A/B
  dsp_opm_skew #(.DEPTH(OPM_SKEW)) u_skew (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (opm_in),
    .dout (dsp_opmode)
  );

  // Job sequencing FSM with registered stream, slice and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      dsp_c     <= '0;
      opm_in    <= OPM_ZERO;
      remaining <= '0;
      drain_cnt <= '0;
      first     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          opm_in <= OPM_ZERO;
          if (start && len != '0) begin
            remaining <= len;
            dsp_c     <= c_init;
            first     <= 1'b1;
            s_ready   <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (s_valid && s_ready) begin
            dsp_a     <= s_a;
            dsp_b     <= s_b;
            opm_in    <= first ? OPM_FIRST : OPM_ACC;
            first     <= 1'b0;
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              s_ready   <= 1'b0;
              drain_cnt <= DW'(LAT_P);
              state     <= DRAIN;
            end
          end else begin
            opm_in <= OPM_HOLD;
          end
        end
        DRAIN: begin
          opm_in <= OPM_HOLD;
          if (drain_cnt == '0) begin
            res_data  <= dsp_p;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          opm_in <= OPM_HOLD;
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DSP_MAC_CARRY_FLAG_EN
  // The slice reports carryout alongside P, LAT_P-OPM_SKEW after dsp_opmode
  logic [7:0] opm_late;
  logic       carry_sticky;
  logic       carry_hit;

  dsp_opm_skew #(.DEPTH(LAT_P - OPM_SKEW)) u_late (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (dsp_opmode),
    .dout (opm_late)
  );

  assign carry_hit = dsp_carryout && (opm_late == OPM_FIRST || opm_late == OPM_ACC);

  // Sticky wraparound flag, captured together with res_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_sticky <= 1'b0;
      res_carry    <= 1'b0;
    end else begin
      if (state == IDLE && start && len != '0) carry_sticky <= 1'b0;
      else if (carry_hit)                      carry_sticky <= 1'b1;
      if (state == DRAIN && drain_cnt == '0)   res_carry <= carry_sticky | carry_hit;
    end
  end
`endif

endmodule
